btn_debounce_n: RTL and testbench
=================================

Name: btn_debounce_n

Overview:
- Parametrised successor to the board push-button/slide-switch input stage.
- Synchronises N raw asynchronous inputs and applies per-channel polarity correction.
- Debounces each channel by requiring STABLE consecutive equal samples on a shared slow sample tick.
- Outputs the debounced level plus one-cycle press/release pulses and an optional auto-repeat pulse for held keys. It sits between the FPGA pins and the CPU/peripheral logic.

Parameters:
- N, 12, number of input channels.
- DIV, 1250000, CLK cycles per sample tick (40 Hz at 50 MHz); legal range 2 or more.
- STABLE, 3, consecutive differing samples required to accept a new level; legal range 1 or more.
- INV_MASK, 12'h003, bit i = 1 means channel i is active-low at the pin (KEYs); inverted before all other processing.
- REP_EN, 12'h000, bit i = 1 enables auto-repeat on channel i.
- REP_DLY, 20, ticks held before the first REPEAT pulse; 1 or more.
- REP_RATE, 4, ticks between subsequent REPEAT pulses; 1 to REP_DLY.

Ports:
- CLK, input, 1, system clock; all state on its rising edge.
- RST, input, 1, asynchronous active-low reset.
- IN, input, N, raw pin inputs (asynchronous).
- LEVEL, output, N, debounced, polarity-corrected level; 1 means pressed/on.
- PRESS, output, N, one-CLK pulse when LEVEL[i] goes 0 to 1.
- RELEASE, output, N, one-CLK pulse when LEVEL[i] goes 1 to 0.
- REPEAT, output, N, one-CLK auto-repeat pulse.
- TICK, output, 1, sample strobe: high one cycle in every DIV cycles.

Behaviour:
- Reset (RST=0, asynchronous) clears the prescaler, synchronisers, stable counters, repeat counters, LEVEL, PRESS, RELEASE and REPEAT to 0. Outputs read 0 while RST=0. Operation resumes on the first CLK edge after RST returns to 1.
- Prescaler:
  - cnt, width clog2(DIV), counts 0..DIV-1 and wraps to 0.
  - TICK = (cnt == DIV-1), combinational from cnt.
  - After reset, the first TICK occurs at the DIV-th rising edge.
- Synchroniser: s = IN ^ INV_MASK passes through a 2-FF chain clocked every CLK, not gated by TICK. sync2 is the sampled value.
- Debounce, per channel i, evaluated only on TICK:
  - sync2[i] == LEVEL[i]: scnt[i] <= 0. Any agreeing sample cancels a pending change.
  - sync2[i] != LEVEL[i] and scnt[i] == STABLE-1: LEVEL[i] <= sync2[i], scnt[i] <= 0.
  - Otherwise: scnt[i] <= scnt[i]+1. Width is clog2(STABLE+1); scnt never exceeds STABLE-1.
  - With STABLE=1, LEVEL follows sync2 on every tick.
- Edge pulses are registered in the same edge that updates LEVEL. PRESS[i]/RELEASE[i] is high for exactly the one cycle in which the new LEVEL[i] value first appears, and 0 at all other times.
- Latency: an ideal pin step reaches LEVEL after 2 CLK (synchroniser) plus up to STABLE ticks. Bound: 2 + STABLE*DIV cycles.
- Auto-repeat, channels with REP_EN[i]=1 only:
  - rcnt[i] <= 0 whenever LEVEL[i] is 0 or on the PRESS edge.
  - On each TICK with LEVEL[i]=1: if rcnt[i] == REP_DLY-1, pulse REPEAT[i] for one cycle and set rcnt[i] <= REP_DLY-REP_RATE; else rcnt[i] <= rcnt[i]+1.
  - Result: the first REPEAT comes on the REP_DLY-th tick after PRESS, then one every REP_RATE ticks.
  - The PRESS pulse itself never coincides with a REPEAT.
  - Release stops repeating immediately; no REPEAT occurs in the RELEASE cycle or later.
  - Channels with REP_EN=0 tie REPEAT to 0, with no counter logic.
- Channels are fully independent. Simultaneous changes on any subset produce pulses in the same cycle.
- LEVEL, PRESS, RELEASE and REPEAT change only in the cycle following a TICK.

Test Plan (sim parameters DIV=4, STABLE=3, REP_DLY=5, REP_RATE=2, REP_EN=12'h010, INV_MASK=12'h003):
- Reset mid-run: with LEVEL[4]=1, drop RST to 0 asynchronously between edges. Required: all outputs 0 immediately. After release, TICK first fires on the 4th edge.
- Clean press: IN[4] 0 to 1 and held. Required: LEVEL[4]=1 within 14 cycles; exactly one PRESS[4] pulse, coincident with LEVEL rising; no other channel toggles.
- Bounce: IN[4] tick samples 1,1,0,1,1,1. Required: LEVEL[4] rises only after the 6th sample, with a single PRESS. Samples 0,1,0 from an idle 0 leave LEVEL 0 with no pulses.
- Active-low: IN[0] held 1 gives LEVEL[0]=0. Drive IN[0]=0 for 3 ticks: LEVEL[0]=1 and one PRESS[0]. Return IN[0]=1: one RELEASE[0] after 3 ticks.
- Auto-repeat: hold IN[4] after PRESS. Required: REPEAT[4] on ticks 5, 7, 9, ... after PRESS. Release: RELEASE[4] pulse, no further REPEAT. Hold IN[5] equally long: REPEAT[5] stays 0.
- All channels: all IN bits step together. Required: all PRESS bits pulse in the same cycle; STABLE=1 build follows sync2 each tick.

Source files
------------

// File: rtl/btn_debounce_n.sv
// Push-button / slide-switch input stage: 2-FF synchroniser, per-channel polarity
// correction, tick-sampled debounce, press/release pulses and optional auto-repeat.
module btn_debounce_n #(
  parameter int             N        = 12,
  parameter int             DIV      = 1250000,
  parameter int             STABLE   = 3,
  parameter logic [N-1:0]   INV_MASK = 12'h003,
  parameter logic [N-1:0]   REP_EN   = 12'h000,
  parameter int             REP_DLY  = 20,
  parameter int             REP_RATE = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] IN,
  output logic [N-1:0] LEVEL,
  output logic [N-1:0] PRESS,
  output logic [N-1:0] RELEASE,
  output logic [N-1:0] REPEAT,
  output logic         TICK
);

  localparam int             CW          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX     = CW'(DIV - 1);
  localparam int             SW          = (STABLE > 0) ? $clog2(STABLE + 1) : 1;
  localparam logic [SW-1:0]  SCNT_MAX    = SW'(STABLE - 1);
  localparam int             RW          = $clog2(REP_DLY + 1);
  localparam logic [RW-1:0]  RCNT_TOP    = RW'(REP_DLY - 1);
  localparam logic [RW-1:0]  RCNT_RELOAD = RW'(REP_DLY - REP_RATE);

  logic [CW-1:0] r_cnt;
  logic          w_tick;
  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;

  assign w_tick = (r_cnt == CNT_MAX);
  assign TICK   = w_tick;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; async active-low reset puts all state in a known value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Active-low pins are flipped before the chain so everything downstream sees 1 = pressed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= IN ^ INV_MASK;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic [SW-1:0] r_scnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_diff;
    logic          w_accept;

    assign w_diff   = r_sync2[gi] ^ r_level;
    assign w_accept = w_tick & w_diff & (r_scnt == SCNT_MAX);

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_scnt    <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_accept & r_sync2[gi];
        r_release <= w_accept & ~r_sync2[gi];
        if (w_tick) begin
          if (!w_diff || w_accept) begin
            r_scnt <= '0;
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end
        if (w_accept) begin
          r_level <= r_sync2[gi];
        end
      end
    end

    assign LEVEL[gi]   = r_level;
    assign PRESS[gi]   = r_press;
    assign RELEASE[gi] = r_release;

    if (REP_EN[gi]) begin : g_rep
      logic [RW-1:0] r_rcnt;
      logic          r_repeat;

      // While pressed, w_accept can only be the release edge, so it also suppresses REPEAT.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          r_rcnt   <= '0;
          r_repeat <= 1'b0;
        end else begin
          r_repeat <= 1'b0;
          if (!r_level || w_accept) begin
            r_rcnt <= '0;
          end else if (w_tick) begin
            if (r_rcnt == RCNT_TOP) begin
              r_repeat <= 1'b1;
              r_rcnt   <= RCNT_RELOAD;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
      end

      assign REPEAT[gi] = r_repeat;
    end else begin : g_norep
      assign REPEAT[gi] = 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_debounce_n.sv
// Directed bench for btn_debounce_n (DIV=4, STABLE=3, REP_DLY=5, REP_RATE=2, REP_EN=0x010)
// plus a STABLE=1 instance sharing the same pins.
module tb_btn_debounce_n;
  localparam int N = 12;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [N-1:0] IN  = 12'h003;
  logic [N-1:0] LEVEL, PRESS, RELEASE, REPEAT;
  logic         TICK;
  logic [N-1:0] LEVEL1, PRESS1, RELEASE1, REPEAT1;
  logic         TICK1;

  int n_checks = 0;
  int n_fail   = 0;
  int press_cnt [N];
  int rel_cnt   [N];
  int rep_cnt   [N];

  btn_debounce_n #(
    .N(N), .DIV(4), .STABLE(3), .INV_MASK(12'h003), .REP_EN(12'h010),
    .REP_DLY(5), .REP_RATE(2)
  ) u_dut (
    .CLK(CLK), .RST(RST), .IN(IN), .LEVEL(LEVEL), .PRESS(PRESS),
    .RELEASE(RELEASE), .REPEAT(REPEAT), .TICK(TICK)
  );

  btn_debounce_n #(
    .N(N), .DIV(4), .STABLE(1), .INV_MASK(12'h003), .REP_EN(12'h000),
    .REP_DLY(5), .REP_RATE(2)
  ) u_dut_s1 (
    .CLK(CLK), .RST(RST), .IN(IN), .LEVEL(LEVEL1), .PRESS(PRESS1),
    .RELEASE(RELEASE1), .REPEAT(REPEAT1), .TICK(TICK1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (PRESS[i])   press_cnt[i]++;
      if (RELEASE[i]) rel_cnt[i]++;
      if (REPEAT[i])  rep_cnt[i]++;
    end
  endtask

  // From just after a tick edge, four steps land just after the next tick edge.
  task automatic tick();
    repeat (4) step();
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
      rep_cnt[i]   = 0;
    end
  endtask

  function automatic int pulses_except(input int ch);
    int s = 0;
    for (int i = 0; i < N; i++) begin
      if (i != ch) s += press_cnt[i] + rel_cnt[i] + rep_cnt[i];
    end
    return s;
  endfunction

  // Releases reset between edges; TICK must first be high after the 3rd edge
  // so the 4th edge consumes it. Leaves the bench tick-aligned.
  task automatic release_align(input string tag);
    RST = 1'b1;
    step(); check({tag, "_tick_e1"}, TICK, 0);
    step(); check({tag, "_tick_e2"}, TICK, 0);
    step(); check({tag, "_tick_e3"}, TICK, 1);
    step(); check({tag, "_tick_e4"}, TICK, 0);
  endtask

  initial begin
    int seq_bounce [6];
    int seq_glitch [3];
    seq_bounce = '{1, 1, 0, 1, 1, 1};
    seq_glitch = '{0, 1, 0};

    // Power-on reset
    repeat (3) @(posedge CLK);
    #1;
    check("rst_level", LEVEL, 0);
    check("rst_pulses", PRESS | RELEASE | REPEAT, 0);
    check("rst_tick", TICK, 0);
    release_align("por");
    check("idle_level", LEVEL, 0);

    // Clean press / release on channel 4
    clr_counts();
    IN[4] = 1'b1;
    tick(); check("a_level_t1", LEVEL, 0);
    tick(); check("a_level_t2", LEVEL, 0);
    tick(); check("a_level_t3", LEVEL, 12'h010);
    check("a_press_t3", PRESS, 12'h010);
    IN[4] = 1'b0;
    tick(); tick(); check("a_rel_t2", LEVEL, 12'h010);
    tick(); check("a_rel_level", LEVEL, 0);
    check("a_release", RELEASE, 12'h010);
    check("a_press_cnt", press_cnt[4], 1);
    check("a_rel_cnt", rel_cnt[4], 1);
    check("a_rep_cnt", rep_cnt[4], 0);
    check("a_others", pulses_except(4), 0);

    // Bounce: accepted only after three consecutive differing samples
    clr_counts();
    for (int k = 0; k < 6; k++) begin
      IN[4] = seq_bounce[k][0];
      tick();
      check($sformatf("b_level_s%0d", k + 1), LEVEL[4], (k == 5) ? 1 : 0);
    end
    check("b_press_cnt", press_cnt[4], 1);
    IN[4] = 1'b0;
    repeat (3) tick();
    check("b_back_idle", LEVEL[4], 0);
    clr_counts();
    for (int k = 0; k < 3; k++) begin
      IN[4] = seq_glitch[k][0];
      tick();
      check($sformatf("b_glitch_s%0d", k + 1), LEVEL[4], 0);
    end
    IN[4] = 1'b0;
    tick();
    check("b_glitch_pulses", pulses_except(-1), 0);

    // Active-low channel 0
    clr_counts();
    check("c_idle_high_pin", LEVEL[0], 0);
    IN[0] = 1'b0;
    tick(); tick(); check("c_level_t2", LEVEL[0], 0);
    tick(); check("c_level_t3", LEVEL[0], 1);
    check("c_press", PRESS, 12'h001);
    IN[0] = 1'b1;
    tick(); tick(); tick();
    check("c_rel_level", LEVEL[0], 0);
    check("c_release", RELEASE, 12'h001);
    check("c_counts", press_cnt[0] * 16 + rel_cnt[0], 17);
    check("c_others", pulses_except(0), 0);

    // Auto-repeat on channel 4, channel 5 held alongside without repeat
    clr_counts();
    IN[5:4] = 2'b11;
    repeat (3) tick();
    check("d_press", PRESS, 12'h030);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("d_rep_k%0d", k), REPEAT, (k >= 5 && (k % 2) == 1) ? 12'h010 : 12'h000);
    end
    IN[5:4] = 2'b00;
    tick(); check("d_rep_k11", REPEAT, 12'h010);
    tick(); check("d_rep_k12", REPEAT, 0);
    tick(); check("d_rep_k13_rel", REPEAT, 0);
    check("d_release", RELEASE, 12'h030);
    tick(); tick();
    check("d_rep_after", REPEAT, 0);
    check("d_rep4_cnt", rep_cnt[4], 4);
    check("d_rep5_cnt", rep_cnt[5], 0);

    // All channels together; STABLE=1 instance follows sync2 each tick
    clr_counts();
    check("e_s1_idle", LEVEL1, 0);
    IN = 12'hFFC;
    tick();
    check("e_s1_level", LEVEL1, 12'hFFF);
    check("e_s1_press", PRESS1, 12'hFFF);
    check("e_level_t1", LEVEL, 0);
    tick(); tick();
    check("e_level_t3", LEVEL, 12'hFFF);
    check("e_press_all", PRESS, 12'hFFF);
    IN = 12'h003;
    tick();
    check("e_s1_rel_level", LEVEL1, 0);
    check("e_s1_release", RELEASE1, 12'hFFF);
    tick(); tick();
    check("e_release_all", RELEASE, 12'hFFF);
    check("e_level_off", LEVEL, 0);

    // Asynchronous reset mid-run with LEVEL[4] set
    IN[4] = 1'b1;
    repeat (3) tick();
    check("f_level_before", LEVEL, 12'h010);
    #3;
    RST = 1'b0;
    #1;
    check("f_rst_level", LEVEL, 0);
    check("f_rst_s1_level", LEVEL1, 0);
    check("f_rst_pulses", PRESS | RELEASE | REPEAT, 0);
    check("f_rst_tick", TICK, 0);
    IN[4] = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    release_align("f");
    IN[4] = 1'b1;
    repeat (3) tick();
    check("f_resume_level", LEVEL, 12'h010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
